// File: rtl/det_pkg.sv
// Shared widths, FSM states and step tables for the sequential 4x4 determinant engine.
package det_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DET_W  = 4*DATA_W + 2;
  localparam int unsigned M2_W   = 2*DATA_W + 1;
  localparam int unsigned M3_W   = 3*DATA_W + 2;
  localparam int unsigned STEP_W = 5;

  typedef enum logic [2:0] {IDLE, MIN2, MIN3, FINAL, DONE} state_e;

  localparam logic [STEP_W-1:0] MIN2_END   = STEP_W'(11);
  localparam logic [STEP_W-1:0] MIN3_BASE  = STEP_W'(12);
  localparam logic [STEP_W-1:0] MIN3_END   = STEP_W'(23);
  localparam logic [STEP_W-1:0] FINAL_BASE = STEP_W'(24);
  localparam logic [STEP_W-1:0] FINAL_END  = STEP_W'(27);

  // Column pair (i,j) of each rows-2/3 minor m_ij; entries 6-7 are padding.
  localparam logic [1:0] MIN2_I [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
  localparam logic [1:0] MIN2_J [8] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

  // MIN3 step t (0..11): row-1 column, 2x2 minor index (m01..m23 = 0..5), target M0k.
  localparam logic [1:0] MIN3_COL [16] = '{2'd1, 2'd2, 2'd3,  2'd0, 2'd2, 2'd3,
                                           2'd0, 2'd1, 2'd3,  2'd0, 2'd1, 2'd2,
                                           2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [2:0] MIN3_MIN [16] = '{3'd5, 3'd4, 3'd3,  3'd5, 3'd2, 3'd1,
                                           3'd4, 3'd2, 3'd0,  3'd3, 3'd1, 3'd0,
                                           3'd0, 3'd0, 3'd0, 3'd0};
  localparam logic [1:0] MIN3_DST [16] = '{2'd0, 2'd0, 2'd0,  2'd1, 2'd1, 2'd1,
                                           2'd2, 2'd2, 2'd2,  2'd3, 2'd3, 2'd3,
                                           2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic MIN3_SUB   [16] = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0,
                                       1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic MIN3_FIRST [16] = '{1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic MIN3_LAST  [16] = '{1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1,
                                       1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1,
                                       1'b0, 1'b0, 1'b0, 1'b0};

  // Alternating cofactor signs along row 0.
  localparam logic FINAL_SUB [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/det4x4_seq_if.sv
// Start/busy/done handshake between the instruction decoder and the determinant engine.
interface det4x4_seq_if
  import det_pkg::*;
#(
  parameter int unsigned EL_W  = DATA_W,
  parameter int unsigned RES_W = DET_W
);
  logic                    start;
  logic [16*EL_W-1:0]      matrix;
  logic                    busy;
  logic                    done;
  logic signed [RES_W-1:0] det;

  modport master (output start, output matrix, input busy, input done, input det);
  modport slave  (input start, input matrix, output busy, output done, output det);
endinterface

// File: rtl/det_mac.sv
// Shared signed multiply-accumulate: one product per enabled cycle, clr restarts the sum.
module det_mac
  import det_pkg::*;
#(
  parameter int unsigned A_W   = DATA_W,
  parameter int unsigned B_W   = M3_W,
  parameter int unsigned ACC_W = DET_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    sub,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] sum_c
);
  localparam int unsigned PROD_W = A_W + B_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W-1:0]  base;

  assign prod   = PROD_W'(a) * PROD_W'(b);
  assign prod_x = ACC_W'(prod);
  assign base   = clr ? '0 : acc;
  assign sum_c  = sub ? (base - prod_x) : (base + prod_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_c;
    end
  end
endmodule

// File: rtl/det4x4_seq.sv
// Sequential 4x4 determinant: 2x2 minors, then 3x3 minors, then row-0 expansion,
// all through one shared MAC with a fixed 29-cycle latency.
module det4x4_seq
  import det_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  det4x4_seq_if.slave bus
);
  localparam int unsigned B_W = M3_W;

  state_e                  state_q, state_d;
  logic [STEP_W-1:0]       step_q;
  logic signed [DATA_W-1:0] a_q  [16];
  logic signed [M2_W-1:0]  m2_q [6];
  logic signed [M3_W-1:0]  m3_q [4];
  logic                    busy_q, done_q;
  logic signed [DET_W-1:0] det_q;

  logic                    mac_en, mac_clr, mac_sub;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [B_W-1:0]   mac_b;
  logic signed [DET_W-1:0] acc, sum_c;

  logic [3:0] t2, t3;
  logic [2:0] mi;
  logic [1:0] t4;

  // Phase-local step indices into the package tables.
  assign t2 = step_q[3:0];
  assign mi = t2[3:1];
  assign t3 = 4'(step_q - MIN3_BASE);
  assign t4 = 2'(step_q - FINAL_BASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    mac_sub = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = MIN2;
      end
      MIN2: begin
        // Even step: +a2i*a3j (fresh sum); odd step: -a2j*a3i.
        mac_en  = 1'b1;
        mac_clr = ~t2[0];
        mac_sub = t2[0];
        if (!t2[0]) begin
          mac_a = a_q[{2'd2, MIN2_I[mi]}];
          mac_b = B_W'(a_q[{2'd3, MIN2_J[mi]}]);
        end else begin
          mac_a = a_q[{2'd2, MIN2_J[mi]}];
          mac_b = B_W'(a_q[{2'd3, MIN2_I[mi]}]);
        end
        if (step_q == MIN2_END) state_d = MIN3;
      end
      MIN3: begin
        mac_en  = 1'b1;
        mac_clr = MIN3_FIRST[t3];
        mac_sub = MIN3_SUB[t3];
        mac_a   = a_q[{2'd1, MIN3_COL[t3]}];
        mac_b   = B_W'(m2_q[MIN3_MIN[t3]]);
        if (step_q == MIN3_END) state_d = FINAL;
      end
      FINAL: begin
        mac_en  = 1'b1;
        mac_clr = (t4 == 2'd0);
        mac_sub = FINAL_SUB[t4];
        mac_a   = a_q[{2'd0, t4}];
        mac_b   = m3_q[t4];
        if (step_q == FINAL_END) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
    end else if (state_q == IDLE) begin
      step_q <= '0;
    end else if (state_q != DONE) begin
      step_q <= step_q + STEP_W'(1);
    end
  end

  // Operand latch on acceptance; each minor is captured on the edge of its last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) a_q[i]  <= '0;
      for (int i = 0; i < 6; i++)  m2_q[i] <= '0;
      for (int i = 0; i < 4; i++)  m3_q[i] <= '0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        for (int i = 0; i < 16; i++) a_q[i] <= bus.matrix[i*DATA_W +: DATA_W];
      end
      if (state_q == MIN2 && t2[0]) begin
        m2_q[mi] <= M2_W'(sum_c);
      end
      if (state_q == MIN3 && MIN3_LAST[t3]) begin
        m3_q[MIN3_DST[t3]] <= M3_W'(sum_c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      det_q  <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == DONE);
      if (state_q == DONE) det_q <= acc;
    end
  end

  det_mac #(
    .A_W  (DATA_W),
    .B_W  (B_W),
    .ACC_W(DET_W)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mac_en),
    .clr  (mac_clr),
    .sub  (mac_sub),
    .a    (mac_a),
    .b    (mac_b),
    .acc  (acc),
    .sum_c(sum_c)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.det  = det_q;

endmodule

// File: tb/tb_det4x4_seq.sv
// Directed bench for det4x4_seq: scoreboard of expected determinants, checked at each done.
module tb_det4x4_seq;
  import det_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  det4x4_seq_if bus ();
  det4x4_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int el [16];
  logic signed [63:0] exp_q [$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [16*DATA_W-1:0] pack_el();
    logic [16*DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i*DATA_W +: DATA_W] = DATA_W'(el[i]);
    return m;
  endfunction

  // Leibniz sum over all 24 permutations.
  function automatic longint model_det();
    longint s, p;
    int inv;
    s = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          for (int l = 0; l < 4; l++)
            if (i != j && i != k && i != l && j != k && j != l && k != l) begin
              inv = int'(i > j) + int'(i > k) + int'(i > l) + int'(j > k) + int'(j > l) + int'(k > l);
              p = longint'(el[i]) * el[4+j] * el[8+k] * el[12+l];
              s = (inv % 2 == 1) ? s - p : s + p;
            end
    return s;
  endfunction

  function automatic void set_diag(input int v);
    for (int i = 0; i < 16; i++) el[i] = (i / 4 == i % 4) ? v : 0;
  endfunction

  function automatic void set_random();
    for (int i = 0; i < 16; i++) el[i] = int'($urandom_range(255)) - 128;
  endfunction

  function automatic void swap_rows(input int r0, input int r1);
    int t;
    for (int c = 0; c < 4; c++) begin
      t = el[4*r0+c]; el[4*r0+c] = el[4*r1+c]; el[4*r1+c] = t;
    end
  endfunction

  task automatic apply(input logic signed [63:0] expv, input bit hold);
    @(negedge clk);
    bus.matrix = pack_el();
    bus.start  = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  // Entered n0 cycles after the acceptance edge; done is expected 29 edges after it.
  task automatic wait_done(input string tag, input int n0);
    int n;
    bit ok;
    logic signed [63:0] e;
    n  = n0;
    ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done !== 1'b1 && !(bus.busy === 1'b1 && bus.done === 1'b0)) ok = 1'b0;
    end
    chk({tag, "_latency"}, 64'(n), 64'(29));
    chk({tag, "_busy_run"}, 64'(ok), 64'(1));
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_det"}, 64'(bus.det), e);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    bit ok;
    ok = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) ok = 1'b0;
    end
    chk(tag, 64'(ok), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [63:0] ea, eb;
    bus.start  = 1'b0;
    bus.matrix = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_det", 64'(bus.det), 64'(0));
    rst_n = 1'b1;
    idle_watch("idle_no_start", 3);

    set_diag(1);
    apply(64'sd1, 1'b0);
    wait_done("identity", 0);

    set_diag(-128);
    apply(64'sd268435456, 1'b0);
    wait_done("diag_m128", 0);

    // Hadamard pattern: +1 entries become -128, -1 entries 127 (+128 is not representable).
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        el[4*r+c] = ($countones(r & c) % 2 == 1) ? 127 : -128;
    apply(64'(model_det()), 1'b0);
    wait_done("hadamard", 0);
    swap_rows(1, 2);
    apply(64'(model_det()), 1'b0);
    wait_done("hadamard_neg", 0);

    set_random();
    for (int c = 0; c < 4; c++) el[12+c] = el[8+c];
    apply(64'sd0, 1'b0);
    wait_done("rows23_equal", 0);

    for (int t = 0; t < 3; t++) begin
      set_random();
      apply(64'(model_det()), 1'b0);
      wait_done("random", 0);
    end

    // Matrix change at E3 and start re-asserted at E5..E9 must not disturb the job.
    set_random();
    apply(64'(model_det()), 1'b0);
    repeat (3) @(negedge clk);
    set_random();
    bus.matrix = pack_el();
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_start", 10);
    idle_watch("no_queued_job", 35);

    set_diag(1);
    swap_rows(0, 1);
    apply(-64'sd1, 1'b0);
    wait_done("swap01", 0);

    // Abort during MIN3: outputs clear at once, no done for the aborted job.
    set_random();
    apply(64'(model_det()), 1'b0);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_det", 64'(bus.det), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_watch("abort_no_done", 35);
    set_random();
    apply(64'(model_det()), 1'b0);
    wait_done("after_abort", 0);

    // start held high: jobs accepted at E0 and E30, done at E29 and E59.
    set_random();
    ea = 64'(model_det());
    apply(ea, 1'b1);
    set_random();
    eb = 64'(model_det());
    bus.matrix = pack_el();
    exp_q.push_back(eb);
    wait_done("b2b_first", 0);
    bus.start = 1'b0;
    wait_done("b2b_second", 0);
    idle_watch("b2b_idle", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
